// File: rtl/fifo_param_tn_pkg.sv
// Shared types and helpers for the event-capture FIFO.
// Default widths match the 24-bit {addr,data} capture word and a 2048-entry buffer.
package fifo_pkg;

    localparam int unsigned DEF_DATA_W = 24;
    localparam int unsigned DEF_ADDR_W = 11;

    typedef logic [DEF_DATA_W-1:0] ev_word_t;
    typedef logic [DEF_ADDR_W-1:0] ptr_t;
    typedef logic [DEF_ADDR_W:0]   level_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_param_tn_if.sv
// Push/pop, status and error-accounting signals of the FIFO, grouped as one bus.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_param_tn_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DROP_W = 16
);

    logic              clear;
    logic              push_s;
    logic [DATA_W-1:0] push_dt;
    logic              pop_s;
    logic [DATA_W-1:0] pop_dt;
    logic              pop_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              err_clr;

    modport master (
        output clear, push_s, push_dt, pop_s, err_clr,
        input  pop_dt, pop_valid, empty, full, almost_full, almost_empty,
               level, overflow, underflow, drop_cnt
    );

    modport slave (
        input  clear, push_s, push_dt, pop_s, err_clr,
        output pop_dt, pop_valid, empty, full, almost_full, almost_empty,
               level, overflow, underflow, drop_cnt
    );

endinterface

// File: rtl/fifo_param_tn_sdp_ram.sv
// Simple dual-port RAM with a registered read port, shaped for block-RAM inference.
// The read register holds its value unless re is high.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // NOTE: the array has no reset branch; a reset loop would block RAM inference,
    // and stale contents are never visible because level gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param_tn.sv
// Single-clock FIFO using every RAM slot, tracked by an occupancy count, with
// almost-full/empty thresholds, flush, and sticky error/drop accounting.
module fifo_param_tn
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned AFULL_TH  = 2000,
    parameter int unsigned AEMPTY_TH = 16,
    parameter int unsigned DROP_W    = 16
) (
    input  logic           clk,
    input  logic           nreset,
    fifo_param_tn_if.slave bus
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);
    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              pop_valid_q, pop_valid_d;
    err_flags_t        err_q, err_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic empty, full;
    logic push_acc, pop_acc, push_rej, pop_rej;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));

    // No bypass: a pop on an empty FIFO is rejected even if a push lands the same cycle.
    always_comb begin
        pop_acc  = bus.pop_s & ~empty & ~bus.clear;
        push_acc = bus.push_s & (~full | pop_acc) & ~bus.clear;
        push_rej = bus.push_s & ~bus.clear & ~push_acc;
        pop_rej  = bus.pop_s & ~bus.clear & empty;
    end

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        pop_valid_d = pop_acc;
        if (bus.clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_acc) wptr_d = wptr_q + ADDR_W'(1);
            if (pop_acc)  rptr_d = rptr_q + ADDR_W'(1);
            level_d = level_q + LVL_W'(push_acc) - LVL_W'(pop_acc);
        end
    end

    // A fresh error in the same cycle as err_clr takes precedence over the clear.
    always_comb begin
        err_d      = err_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.err_clr) begin
            err_d.overflow  = push_rej;
            err_d.underflow = pop_rej;
            drop_cnt_d      = push_rej ? DROP_W'(1) : '0;
        end else begin
            err_d.overflow  = err_q.overflow | push_rej;
            err_d.underflow = err_q.underflow | pop_rej;
            if (push_rej && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            pop_valid_q <= 1'b0;
            err_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            pop_valid_q <= pop_valid_d;
            err_q       <= err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .nreset (nreset),
        .we     (push_acc),
        .waddr  (wptr_q),
        .wdata  (bus.push_dt),
        .re     (pop_acc),
        .raddr  (rptr_q),
        .rdata  (bus.pop_dt)
    );

    assign bus.pop_valid    = pop_valid_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_full  = (level_q >= LVL_W'(AFULL_TH));
    assign bus.almost_empty = (level_q <= LVL_W'(AEMPTY_TH));
    assign bus.level        = level_q;
    assign bus.overflow     = err_q.overflow;
    assign bus.underflow    = err_q.underflow;
    assign bus.drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_fifo_param_tn.sv
// Bench for fifo_param_tn: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_param_tn;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int DRW   = 4;
    localparam int DEPTH = 16;
    localparam int DMAX  = (1 << DRW) - 1;

    logic clk    = 1'b0;
    logic nreset = 1'b0;

    fifo_param_tn_if #(.DATA_W(DW), .ADDR_W(AW), .DROP_W(DRW)) bus ();

    fifo_param_tn #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE),
        .DROP_W    (DRW)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of stored words plus error bookkeeping.
    logic [DW-1:0] mq [$];
    logic          m_valid;
    logic [DW-1:0] m_dt;
    logic          m_ovf, m_unf;
    int            m_drop;
    bit            m_live = 1'b0;

    initial forever begin : model
        int n;
        bit do_pop, do_push, push_err, pop_err;
        @(posedge clk);
        if (!nreset) begin
            mq.delete();
            m_valid = 1'b0;
            m_dt    = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_drop  = 0;
            m_live  = 1'b1;
        end else begin
            n        = mq.size();
            push_err = 1'b0;
            pop_err  = 1'b0;
            if (bus.clear) begin
                mq.delete();
                m_valid = 1'b0;
            end else begin
                do_pop   = bus.pop_s && (n > 0);
                do_push  = bus.push_s && ((n < DEPTH) || do_pop);
                push_err = bus.push_s && !do_push;
                pop_err  = bus.pop_s && (n == 0);
                m_valid  = do_pop;
                if (do_pop)  m_dt = mq.pop_front();
                if (do_push) mq.push_back(bus.push_dt);
            end
            if (bus.err_clr) begin
                m_ovf  = push_err;
                m_unf  = pop_err;
                m_drop = push_err ? 1 : 0;
            end else begin
                m_ovf = m_ovf | push_err;
                m_unf = m_unf | pop_err;
                if (push_err && (m_drop < DMAX)) m_drop++;
            end
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (m_live) begin
            check("pop_valid", bus.pop_valid, m_valid);
            check("pop_dt", bus.pop_dt, m_dt);
            check("level", bus.level, mq.size());
            check("empty", bus.empty, mq.size() == 0);
            check("full", bus.full, mq.size() == DEPTH);
            check("almost_full", bus.almost_full, mq.size() >= AF);
            check("almost_empty", bus.almost_empty, mq.size() <= AE);
            check("overflow", bus.overflow, m_ovf);
            check("underflow", bus.underflow, m_unf);
            check("drop_cnt", bus.drop_cnt, m_drop);
        end
    end

    task automatic cyc(input bit push, input logic [DW-1:0] dt, input bit pop,
                       input bit clr = 1'b0, input bit eclr = 1'b0);
        bus.push_s  = push;
        bus.push_dt = dt;
        bus.pop_s   = pop;
        bus.clear   = clr;
        bus.err_clr = eclr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n = 1);
        repeat (n) cyc(1'b0, '0, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        bus.push_s  = 1'b0;
        bus.push_dt = '0;
        bus.pop_s   = 1'b0;
        bus.clear   = 1'b0;
        bus.err_clr = 1'b0;
        nreset      = 1'b0;
        idle(2);
        nreset = 1'b1;
        check("rst_empty", bus.empty, 1);
        check("rst_aempty", bus.almost_empty, 1);
        check("rst_level", bus.level, 0);
        check("rst_full", bus.full, 0);
        check("rst_pop_dt", bus.pop_dt, 0);

        // 1: fill to full, then drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, DW'(i), 1'b0);
            if (i == 13) check("t1_afull_13", bus.almost_full, 0);
            if (i == 14) check("t1_afull_14", bus.almost_full, 1);
        end
        check("t1_full", bus.full, 1);
        check("t1_level", bus.level, 16);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, '0, 1'b1);
            check("t1_pop_valid", bus.pop_valid, 1);
            check("t1_pop_dt", bus.pop_dt, i);
        end
        idle();
        check("t1_empty", bus.empty, 1);
        check("t1_valid_low", bus.pop_valid, 0);

        // 2: overflow while full, drop counter saturates
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(32'h100 + i), 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'(32'hDEAD00 + i), 1'b0);
        check("t2_overflow", bus.overflow, 1);
        check("t2_drop_sat", bus.drop_cnt, 15);
        check("t2_level", bus.level, 16);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, '0, 1'b1);
            check("t2_pop_dt", bus.pop_dt, 32'h100 + i);
        end
        idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t2_ovf_clr", bus.overflow, 0);
        check("t2_drop_clr", bus.drop_cnt, 0);

        // 3: underflow, and push+pop together on empty
        cyc(1'b0, '0, 1'b1);
        check("t3_underflow", bus.underflow, 1);
        check("t3_no_valid", bus.pop_valid, 0);
        check("t3_dt_hold", bus.pop_dt, 32'h10F);
        cyc(1'b1, 24'h00AA55, 1'b1);
        check("t3_level", bus.level, 1);
        check("t3_no_valid2", bus.pop_valid, 0);
        cyc(1'b0, '0, 1'b1);
        check("t3_pop_dt", bus.pop_dt, 32'h00AA55);
        check("t3_valid", bus.pop_valid, 1);
        idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t3_unf_clr", bus.underflow, 0);

        // 4: push+pop while full
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(32'h200 + i), 1'b0);
        cyc(1'b1, 24'hABCDEF, 1'b1);
        check("t4_level", bus.level, 16);
        check("t4_no_ovf", bus.overflow, 0);
        check("t4_pop_dt", bus.pop_dt, 32'h200);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, '0, 1'b1);
            check("t4_drain", bus.pop_dt, (i < 15) ? 32'h201 + i : 32'hABCDEF);
        end
        idle();
        check("t4_empty", bus.empty, 1);

        // 5: steady level 3 across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h300 + i), 1'b0);
        idle();
        check("t5_level3", bus.level, 3);
        check("t5_aempty3", bus.almost_empty, 0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, DW'(32'h303 + k), 1'b1);
            check("t5_wrap_level", bus.level, 3);
            check("t5_wrap_dt", bus.pop_dt, 32'h300 + k);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("t5_tail_dt", bus.pop_dt, 32'h328 + k);
            if (k == 0) check("t5_aempty2", bus.almost_empty, 1);
        end
        idle();

        // 6: clear with push in same cycle, then reset mid-burst
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(32'h400 + i), 1'b0);
        cyc(1'b1, 24'h4FF, 1'b0);
        cyc(1'b1, 24'h4FF, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1);
        idle();
        check("t6_level9", bus.level, 9);
        cyc(1'b1, 24'h555, 1'b0, 1'b1);
        check("t6_clr_level", bus.level, 0);
        check("t6_clr_empty", bus.empty, 1);
        check("t6_clr_drop", bus.drop_cnt, 2);
        check("t6_clr_ovf", bus.overflow, 1);
        cyc(1'b1, 24'h600, 1'b0);
        cyc(1'b1, 24'h601, 1'b1);
        nreset = 1'b0;
        cyc(1'b1, 24'h602, 1'b1);
        check("t6_rst_level", bus.level, 0);
        check("t6_rst_valid", bus.pop_valid, 0);
        check("t6_rst_dt", bus.pop_dt, 0);
        check("t6_rst_ovf", bus.overflow, 0);
        check("t6_rst_drop", bus.drop_cnt, 0);
        check("t6_rst_empty", bus.empty, 1);
        nreset = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
